// File: rtl/cmd_pkg.sv
// Shared opcode, response and state definitions for the flight command dispatcher.
package cmd_pkg;

  typedef enum logic [7:0] {
    OP_SET_PTCH  = 8'h02,
    OP_SET_ROLL  = 8'h03,
    OP_SET_YAW   = 8'h04,
    OP_SET_THRST = 8'h05,
    OP_CALIBRATE = 8'h06,
    OP_EMER_LAND = 8'h07,
    OP_MTRS_OFF  = 8'h08
  } opcode_e;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  typedef enum logic [1:0] {
    IDLE,
    CAL_WAIT,
    SEND,
    WAIT_SENT
  } state_e;

  function automatic logic [7:0] resp_for(input logic [7:0] op);
    logic [7:0] r;
    case (op)
      OP_SET_PTCH, OP_SET_ROLL, OP_SET_YAW, OP_SET_THRST,
      OP_CALIBRATE, OP_EMER_LAND, OP_MTRS_OFF: r = ACK;
      default:                                 r = NAK;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmd_wdog.sv
// Link-loss watchdog: counts cycles since the last accepted command and pulses
// expire on the cycle whose edge would bring the count to WDOG_CYCLES.
module cmd_wdog #(
  parameter int WDOG_CYCLES = 4_000_000,
  parameter int WDOG_W      = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic expire
);

  localparam logic [WDOG_W-1:0] LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  // A kick in the expiry cycle suppresses the expiry: the command wins.
  assign expire = (cnt_q == LAST) && !kick;

  always_comb begin
    cnt_d = cnt_q + WDOG_W'(1);
    if (kick || expire) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cmd_dispatch.sv
// Command processor: accepts framed commands, updates flight setpoints,
// sequences calibration, returns ACK/NAK and enforces the link-loss watchdog.
module cmd_dispatch
  import cmd_pkg::*;
#(
  parameter int WDOG_CYCLES = 4_000_000,
  parameter int WDOG_W      = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_rdy,
  input  logic [7:0]         cmd,
  input  logic [15:0]        data,
  input  logic               resp_sent,
  input  logic               cal_done,
  output logic               clr_cmd_rdy,
  output logic               snd_resp,
  output logic [7:0]         resp,
  output logic signed [15:0] d_ptch,
  output logic signed [15:0] d_roll,
  output logic signed [15:0] d_yaw,
  output logic [8:0]         thrst,
  output logic               motors_off,
  output logic               strt_cal,
  output logic               inertial_cal
);

  state_e             state_q;
  logic [7:0]         resp_q;
  logic signed [15:0] d_ptch_q, d_roll_q, d_yaw_q;
  logic [8:0]         thrst_q;
  logic               motors_off_q, strt_cal_q, inertial_cal_q;
  logic               accept, expire;

  assign accept      = (state_q == IDLE) && cmd_rdy;
  assign clr_cmd_rdy = accept;
  assign snd_resp    = (state_q == SEND);

  cmd_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES),
    .WDOG_W     (WDOG_W)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .kick  (accept),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      resp_q         <= '0;
      d_ptch_q       <= '0;
      d_roll_q       <= '0;
      d_yaw_q        <= '0;
      thrst_q        <= '0;
      motors_off_q   <= 1'b1;
      strt_cal_q     <= 1'b0;
      inertial_cal_q <= 1'b0;
    end else begin
      strt_cal_q <= 1'b0;

      // Expiry never coincides with an accept, so the decode below cannot collide with it.
      if (expire) begin
        d_ptch_q <= '0;
        d_roll_q <= '0;
        d_yaw_q  <= '0;
        thrst_q  <= '0;
      end

      case (state_q)
        IDLE: begin
          if (cmd_rdy) begin
            resp_q  <= resp_for(cmd);
            state_q <= SEND;
            case (cmd)
              OP_SET_PTCH:  d_ptch_q <= $signed(data);
              OP_SET_ROLL:  d_roll_q <= $signed(data);
              OP_SET_YAW:   d_yaw_q  <= $signed(data);
              OP_SET_THRST: thrst_q  <= data[8:0];
              OP_CALIBRATE: begin
                motors_off_q   <= 1'b0;
                inertial_cal_q <= 1'b1;
                strt_cal_q     <= 1'b1;
                state_q        <= CAL_WAIT;
              end
              OP_EMER_LAND: begin
                d_ptch_q <= '0;
                d_roll_q <= '0;
                d_yaw_q  <= '0;
                thrst_q  <= '0;
              end
              OP_MTRS_OFF:  motors_off_q <= 1'b1;
              default: ;
            endcase
          end
        end
        CAL_WAIT: begin
          if (cal_done) begin
            inertial_cal_q <= 1'b0;
            state_q        <= SEND;
          end
        end
        // resp_sent is not looked at here: the transmitter's done flag is stale until trmt lands.
        SEND:      state_q <= WAIT_SENT;
        WAIT_SENT: if (resp_sent) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign resp         = resp_q;
  assign d_ptch       = d_ptch_q;
  assign d_roll       = d_roll_q;
  assign d_yaw        = d_yaw_q;
  assign thrst        = thrst_q;
  assign motors_off   = motors_off_q;
  assign strt_cal     = strt_cal_q;
  assign inertial_cal = inertial_cal_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed bench for cmd_dispatch with a 100-cycle watchdog.
`timescale 1ns/1ps
module tb_cmd_dispatch;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_rdy;
  logic [7:0]         cmd;
  logic [15:0]        data;
  logic               resp_sent;
  logic               cal_done;
  logic               clr_cmd_rdy;
  logic               snd_resp;
  logic [7:0]         resp;
  logic signed [15:0] d_ptch, d_roll, d_yaw;
  logic [8:0]         thrst;
  logic               motors_off, strt_cal, inertial_cal;

  int vectors = 0;
  int miscompares = 0;

  cmd_dispatch #(.WDOG_CYCLES(100), .WDOG_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
    .resp_sent(resp_sent), .cal_done(cal_done), .clr_cmd_rdy(clr_cmd_rdy),
    .snd_resp(snd_resp), .resp(resp), .d_ptch(d_ptch), .d_roll(d_roll),
    .d_yaw(d_yaw), .thrst(thrst), .motors_off(motors_off),
    .strt_cal(strt_cal), .inertial_cal(inertial_cal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1, "timeout");
  end

  // Advance to 2ns after the next rising edge; inputs change here, outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_rdy = 1'b0; cmd = '0; data = '0; resp_sent = 1'b0; cal_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  // Present a command, let the accepting edge pass, then drop cmd_rdy as the wrapper would.
  task automatic issue(input logic [7:0] op, input logic [15:0] d);
    cmd_rdy = 1'b1; cmd = op; data = d;
    tick();
    cmd_rdy = 1'b0;
    #1;
  endtask

  // From SEND: step to WAIT_SENT, report the byte sent, return to IDLE.
  task automatic finish_resp();
    tick();
    resp_sent = 1'b1;
    tick();
    resp_sent = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (d_ptch !== 16'h0) begin miscompares++; $display("FAIL rst_ptch got %h exp 0000", d_ptch); end
    vectors++; if (thrst !== 9'h0) begin miscompares++; $display("FAIL rst_thrst got %h exp 000", thrst); end
    vectors++; if (resp !== 8'h00) begin miscompares++; $display("FAIL rst_resp got %h exp 00", resp); end
    vectors++; if (motors_off !== 1'b1) begin miscompares++; $display("FAIL rst_motors_off got %b exp 1", motors_off); end
    vectors++; if ({snd_resp, strt_cal, inertial_cal, clr_cmd_rdy} !== 4'b0000) begin
      miscompares++; $display("FAIL rst_pulses got %b exp 0000", {snd_resp, strt_cal, inertial_cal, clr_cmd_rdy}); end
  endtask

  task automatic test_set_ptch();
    do_reset();
    cmd_rdy = 1'b1; cmd = 8'h02; data = 16'h1234;
    #1;
    vectors++; if (clr_cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL ptch_clr got %b exp 1", clr_cmd_rdy); end
    vectors++; if (snd_resp !== 1'b0) begin miscompares++; $display("FAIL ptch_early_snd got %b exp 0", snd_resp); end
    tick();
    cmd_rdy = 1'b0;
    #1;
    vectors++; if (clr_cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL ptch_clr_width got %b exp 0", clr_cmd_rdy); end
    vectors++; if (d_ptch !== 16'h1234) begin miscompares++; $display("FAIL ptch_val got %h exp 1234", d_ptch); end
    vectors++; if (snd_resp !== 1'b1) begin miscompares++; $display("FAIL ptch_snd got %b exp 1", snd_resp); end
    vectors++; if (resp !== 8'hA5) begin miscompares++; $display("FAIL ptch_resp got %h exp a5", resp); end
    tick();
    cmd_rdy = 1'b1; cmd = 8'h03; data = 16'h0001;
    #1;
    vectors++; if (snd_resp !== 1'b0) begin miscompares++; $display("FAIL ptch_snd_width got %b exp 0", snd_resp); end
    vectors++; if (clr_cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL ptch_busy_clr got %b exp 0", clr_cmd_rdy); end
    resp_sent = 1'b1;
    tick();
    resp_sent = 1'b0;
    #1;
    vectors++; if (clr_cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL ptch_idle_after_sent got %b exp 1", clr_cmd_rdy); end
    cmd_rdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(8'h05, 16'hFFFF);
    cmd_rdy = 1'b1; cmd = 8'h04; data = 16'h8000;
    #1;
    vectors++; if (thrst !== 9'h1FF) begin miscompares++; $display("FAIL b2b_thrst got %h exp 1ff", thrst); end
    vectors++; if (clr_cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL b2b_clr_in_send got %b exp 0", clr_cmd_rdy); end
    tick();
    vectors++; if (d_yaw !== 16'h0000) begin miscompares++; $display("FAIL b2b_yaw_early got %h exp 0000", d_yaw); end
    resp_sent = 1'b1;
    tick();
    resp_sent = 1'b0;
    #1;
    vectors++; if (clr_cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL b2b_pending_taken got %b exp 1", clr_cmd_rdy); end
    tick();
    cmd_rdy = 1'b0;
    #1;
    vectors++; if (d_yaw !== 16'h8000) begin miscompares++; $display("FAIL b2b_yaw got %h exp 8000", d_yaw); end
    vectors++; if (thrst !== 9'h1FF) begin miscompares++; $display("FAIL b2b_thrst_kept got %h exp 1ff", thrst); end
    vectors++; if (snd_resp !== 1'b1) begin miscompares++; $display("FAIL b2b_snd got %b exp 1", snd_resp); end
    finish_resp();
  endtask

  task automatic test_calibrate();
    int strt_cnt;
    int snd_cnt;
    int cal_low;
    do_reset();
    issue(8'h06, 16'h0000);
    strt_cnt = 0; snd_cnt = 0; cal_low = 0;
    vectors++; if (motors_off !== 1'b0) begin miscompares++; $display("FAIL cal_motors_off got %b exp 0", motors_off); end
    vectors++; if (strt_cal !== 1'b1) begin miscompares++; $display("FAIL cal_strt got %b exp 1", strt_cal); end
    vectors++; if (inertial_cal !== 1'b1) begin miscompares++; $display("FAIL cal_inertial got %b exp 1", inertial_cal); end
    for (int i = 0; i < 49; i++) begin
      tick(); #1;
      if (strt_cal) strt_cnt++;
      if (snd_resp) snd_cnt++;
      if (!inertial_cal) cal_low++;
    end
    vectors++; if (strt_cnt !== 0) begin miscompares++; $display("FAIL cal_strt_extra got %0d exp 0", strt_cnt); end
    vectors++; if (snd_cnt !== 0) begin miscompares++; $display("FAIL cal_snd_early got %0d exp 0", snd_cnt); end
    vectors++; if (cal_low !== 0) begin miscompares++; $display("FAIL cal_inertial_drop got %0d exp 0", cal_low); end
    cal_done = 1'b1;
    #1;
    vectors++; if (snd_resp !== 1'b0) begin miscompares++; $display("FAIL cal_snd_same_cycle got %b exp 0", snd_resp); end
    tick();
    cal_done = 1'b0;
    #1;
    vectors++; if (snd_resp !== 1'b1) begin miscompares++; $display("FAIL cal_snd got %b exp 1", snd_resp); end
    vectors++; if (inertial_cal !== 1'b0) begin miscompares++; $display("FAIL cal_inertial_end got %b exp 0", inertial_cal); end
    vectors++; if (resp !== 8'hA5) begin miscompares++; $display("FAIL cal_resp got %h exp a5", resp); end
    finish_resp();
  endtask

  task automatic test_undefined();
    do_reset();
    issue(8'h03, 16'h0042);
    finish_resp();
    issue(8'h3C, 16'hFFFF);
    vectors++; if (resp !== 8'hEE) begin miscompares++; $display("FAIL undef_resp got %h exp ee", resp); end
    vectors++; if (snd_resp !== 1'b1) begin miscompares++; $display("FAIL undef_snd got %b exp 1", snd_resp); end
    vectors++; if ({d_ptch, d_roll, d_yaw} !== {16'h0000, 16'h0042, 16'h0000}) begin
      miscompares++; $display("FAIL undef_setpts got %h %h %h exp 0000 0042 0000", d_ptch, d_roll, d_yaw); end
    vectors++; if ({thrst, motors_off} !== {9'h000, 1'b1}) begin
      miscompares++; $display("FAIL undef_thrst_mo got %h %b exp 000 1", thrst, motors_off); end
    finish_resp();
  endtask

  task automatic test_emer_mtrs();
    do_reset();
    issue(8'h06, 16'h0000);
    cal_done = 1'b1; tick(); cal_done = 1'b0;
    finish_resp();
    issue(8'h04, 16'h7FFF); finish_resp();
    issue(8'h07, 16'h1111);
    vectors++; if ({d_yaw, motors_off, resp} !== {16'h0000, 1'b0, 8'hA5}) begin
      miscompares++; $display("FAIL emer_land got %h %b %h exp 0000 0 a5", d_yaw, motors_off, resp); end
    finish_resp();
    issue(8'h08, 16'h0000);
    vectors++; if (motors_off !== 1'b1) begin miscompares++; $display("FAIL mtrs_off got %b exp 1", motors_off); end
    finish_resp();
  endtask

  task automatic test_watchdog();
    int snd_cnt;
    do_reset();
    issue(8'h06, 16'h0000);
    cal_done = 1'b1; tick(); cal_done = 1'b0;
    finish_resp();
    issue(8'h05, 16'h00AB); finish_resp();
    issue(8'h02, 16'h0101);
    finish_resp();
    snd_cnt = 0;
    for (int i = 0; i < 97; i++) begin
      tick(); #1;
      if (snd_resp) snd_cnt++;
    end
    vectors++; if ({d_ptch, thrst} !== {16'h0101, 9'h0AB}) begin
      miscompares++; $display("FAIL wdog_early got %h %h exp 0101 0ab", d_ptch, thrst); end
    tick(); #1;
    vectors++; if ({d_ptch, thrst} !== {16'h0000, 9'h000}) begin
      miscompares++; $display("FAIL wdog_expire got %h %h exp 0000 000", d_ptch, thrst); end
    vectors++; if (motors_off !== 1'b0) begin miscompares++; $display("FAIL wdog_motors_off got %b exp 0", motors_off); end
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      if (snd_resp) snd_cnt++;
    end
    vectors++; if (snd_cnt !== 0) begin miscompares++; $display("FAIL wdog_snd got %0d exp 0", snd_cnt); end

    issue(8'h02, 16'h0202);
    finish_resp();
    for (int i = 0; i < 97; i++) tick();
    cmd_rdy = 1'b1; cmd = 8'h03; data = 16'h0077;
    tick();
    cmd_rdy = 1'b0;
    #1;
    vectors++; if ({d_ptch, d_roll} !== {16'h0202, 16'h0077}) begin
      miscompares++; $display("FAIL wdog_kick_wins got %h %h exp 0202 0077", d_ptch, d_roll); end
    finish_resp();
    for (int i = 0; i < 40; i++) tick();
    #1;
    vectors++; if (d_ptch !== 16'h0202) begin miscompares++; $display("FAIL wdog_restart got %h exp 0202", d_ptch); end
  endtask

  task automatic test_reset_mid();
    int snd_cnt;
    do_reset();
    issue(8'h03, 16'h0042);
    tick();
    #1;
    vectors++; if (d_roll !== 16'h0042) begin miscompares++; $display("FAIL rmid_pre got %h exp 0042", d_roll); end
    rst = 1'b1;
    #1;
    vectors++; if ({d_roll, resp, motors_off} !== {16'h0000, 8'h00, 1'b1}) begin
      miscompares++; $display("FAIL rmid_vals got %h %h %b exp 0000 00 1", d_roll, resp, motors_off); end
    vectors++; if ({snd_resp, strt_cal, inertial_cal, clr_cmd_rdy} !== 4'b0000) begin
      miscompares++; $display("FAIL rmid_pulses got %b exp 0000", {snd_resp, strt_cal, inertial_cal, clr_cmd_rdy}); end
    tick();
    rst = 1'b0;
    snd_cnt = 0;
    resp_sent = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      if (snd_resp) snd_cnt++;
    end
    resp_sent = 1'b0;
    vectors++; if (snd_cnt !== 0) begin miscompares++; $display("FAIL rmid_snd got %0d exp 0", snd_cnt); end
  endtask

  initial begin
    test_reset();
    test_set_ptch();
    test_back_to_back();
    test_calibrate();
    test_undefined();
    test_emer_mtrs();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
